// File: rtl/fu_issue_scheduler_pkg.sv
// Shared definitions for the functional-unit issue scheduler and the
// reservation station that feeds it.
package fu_issue_scheduler_pkg;

    // Execution unit numbering; also the bit position in grant_valid.
    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_MEM  = 2;
    localparam int NUM_FU  = 3;

    // Major opcodes the station decodes to derive req_mem (lw/sw -> MEM class).
    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;

endpackage

// File: rtl/fu_issue_scheduler_age_picker.sv
// Oldest-of-N selector. Age is the ROB distance from head (unsigned wrap);
// the smallest distance wins and ties go to the lowest index.
module age_picker
    import fu_issue_scheduler_pkg::*;
#(
    parameter int N     = 32,
    parameter int IDX_W = 5,
    parameter int AGE_W = 5
) (
    input  logic [N-1:0]       cand,
    input  logic [N-1:0]       excl,
    input  logic [N*AGE_W-1:0] age,
    input  logic [AGE_W-1:0]   head,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic               found_s;
    logic [IDX_W-1:0]   idx_s;
    logic [AGE_W-1:0]   best_s;
    logic [AGE_W-1:0]   dist_s;

    // Linear scan in ascending index order; strict less-than keeps the lower index on ties.
    always_comb begin
        found_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        best_s  = {AGE_W{1'b0}};
        dist_s  = {AGE_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            dist_s = age[i*AGE_W +: AGE_W] - head;
            if (cand[i] && !excl[i] && (!found_s || (dist_s < best_s))) begin
                found_s = 1'b1;
                idx_s   = IDX_W'(i);
                best_s  = dist_s;
            end else begin
                best_s  = best_s;
            end
        end
    end

    assign found = found_s;
    assign idx   = idx_s;

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue scheduler: picks the two oldest ready ALU entries and the oldest
// ready MEM entry each cycle, registers the grants and clear strobes, and
// tracks MEM-unit occupancy through the mem_done handshake.
module fu_issue_scheduler
    import fu_issue_scheduler_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int IDX_W       = 5,
    parameter int ROB_W       = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_ENTRIES-1:0]       req_ready,
    input  logic [NUM_ENTRIES-1:0]       req_mem,
    input  logic [NUM_ENTRIES*ROB_W-1:0] req_age,
    input  logic [ROB_W-1:0]             rob_head,
    input  logic                         mem_done,
    output logic [NUM_FU-1:0]            grant_valid,
    output logic [NUM_FU*IDX_W-1:0]      grant_idx,
    output logic [NUM_ENTRIES-1:0]       clear_entry,
    output logic                         mem_busy
);

    logic [NUM_FU-1:0]       grant_valid_r;
    logic [NUM_FU*IDX_W-1:0] grant_idx_r;
    logic [NUM_ENTRIES-1:0]  clear_entry_r;
    logic                    mem_busy_r;

    logic [NUM_ENTRIES-1:0]  elig_s;
    logic [NUM_ENTRIES-1:0]  alu_cand_s;
    logic [NUM_ENTRIES-1:0]  mem_cand_s;
    logic [NUM_ENTRIES-1:0]  first_oh_s;
    logic                    first_found_s;
    logic [IDX_W-1:0]        first_idx_s;
    logic                    second_found_s;
    logic [IDX_W-1:0]        second_idx_s;
    logic                    mem_found_s;
    logic [IDX_W-1:0]        mem_idx_s;
    logic                    mem_free_s;
    logic [NUM_FU-1:0]       gv_nxt_s;
    logic [NUM_FU*IDX_W-1:0] gi_nxt_s;
    logic [NUM_ENTRIES-1:0]  clr_nxt_s;
    logic                    busy_nxt_s;

    // Last cycle's clear strobes mask entries the station has not yet freed.
    always_comb begin
        elig_s     = req_ready & ~clear_entry_r;
        alu_cand_s = elig_s & ~req_mem;
        mem_cand_s = elig_s & req_mem;
        mem_free_s = !mem_busy_r || mem_done;
    end

    age_picker #(.N(NUM_ENTRIES), .IDX_W(IDX_W), .AGE_W(ROB_W)) u_pick_alu0 (
        .cand(alu_cand_s), .excl({NUM_ENTRIES{1'b0}}), .age(req_age), .head(rob_head),
        .found(first_found_s), .idx(first_idx_s)
    );

    age_picker #(.N(NUM_ENTRIES), .IDX_W(IDX_W), .AGE_W(ROB_W)) u_pick_alu1 (
        .cand(alu_cand_s), .excl(first_oh_s), .age(req_age), .head(rob_head),
        .found(second_found_s), .idx(second_idx_s)
    );

    age_picker #(.N(NUM_ENTRIES), .IDX_W(IDX_W), .AGE_W(ROB_W)) u_pick_mem (
        .cand(mem_cand_s), .excl({NUM_ENTRIES{1'b0}}), .age(req_age), .head(rob_head),
        .found(mem_found_s), .idx(mem_idx_s)
    );

    // Next grants, clear strobes and MEM occupancy from this cycle's picks.
    always_comb begin
        gv_nxt_s   = {NUM_FU{1'b0}};
        gi_nxt_s   = {(NUM_FU*IDX_W){1'b0}};
        clr_nxt_s  = {NUM_ENTRIES{1'b0}};
        first_oh_s = {NUM_ENTRIES{1'b0}};

        gv_nxt_s[FU_ALU0] = first_found_s;
        gv_nxt_s[FU_ALU1] = first_found_s && second_found_s;
        gv_nxt_s[FU_MEM]  = mem_found_s && mem_free_s;

        gi_nxt_s[FU_ALU0*IDX_W +: IDX_W] = gv_nxt_s[FU_ALU0] ? first_idx_s  : {IDX_W{1'b0}};
        gi_nxt_s[FU_ALU1*IDX_W +: IDX_W] = gv_nxt_s[FU_ALU1] ? second_idx_s : {IDX_W{1'b0}};
        gi_nxt_s[FU_MEM*IDX_W  +: IDX_W] = gv_nxt_s[FU_MEM]  ? mem_idx_s    : {IDX_W{1'b0}};

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            first_oh_s[i] = first_found_s && (first_idx_s == IDX_W'(i));
            clr_nxt_s[i]  = (gv_nxt_s[FU_ALU0] && (first_idx_s  == IDX_W'(i))) ||
                            (gv_nxt_s[FU_ALU1] && (second_idx_s == IDX_W'(i))) ||
                            (gv_nxt_s[FU_MEM]  && (mem_idx_s    == IDX_W'(i)));
        end

        if (gv_nxt_s[FU_MEM]) begin
            busy_nxt_s = 1'b1;
        end else if (mem_done) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = mem_busy_r;
        end
    end

    // Output registers; flush drops pending work but keeps the last indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid_r <= {NUM_FU{1'b0}};
            grant_idx_r   <= {(NUM_FU*IDX_W){1'b0}};
            clear_entry_r <= {NUM_ENTRIES{1'b0}};
            mem_busy_r    <= 1'b0;
        end else if (flush) begin
            grant_valid_r <= {NUM_FU{1'b0}};
            clear_entry_r <= {NUM_ENTRIES{1'b0}};
            mem_busy_r    <= 1'b0;
        end else begin
            grant_valid_r <= gv_nxt_s;
            grant_idx_r   <= gi_nxt_s;
            clear_entry_r <= clr_nxt_s;
            mem_busy_r    <= busy_nxt_s;
        end
    end

    assign grant_valid = grant_valid_r;
    assign grant_idx   = grant_idx_r;
    assign clear_entry = clear_entry_r;
    assign mem_busy    = mem_busy_r;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Scoreboard bench for fu_issue_scheduler: each scenario task drives one
// cycle of inputs, queues the hand-derived expected outputs, and compares
// them one edge later.
module tb_fu_issue_scheduler;

    localparam int NE = 32;
    localparam int IW = 5;
    localparam int RW = 5;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [NE-1:0]    req_ready;
    logic [NE-1:0]    req_mem;
    logic [NE*RW-1:0] req_age;
    logic [RW-1:0]    rob_head;
    logic             mem_done;
    logic [2:0]       grant_valid;
    logic [3*IW-1:0]  grant_idx;
    logic [NE-1:0]    clear_entry;
    logic             mem_busy;

    typedef struct {
        string          name;
        logic [2:0]     gv;
        logic [3*IW-1:0] gi;
        logic [NE-1:0]  clr;
        logic           busy;
        bit             chk_gi;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    fu_issue_scheduler #(.NUM_ENTRIES(NE), .IDX_W(IW), .ROB_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_ready(req_ready),
        .req_mem(req_mem), .req_age(req_age), .rob_head(rob_head),
        .mem_done(mem_done), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .clear_entry(clear_entry), .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0; mem_done = 1'b0;
        req_ready = '0; req_mem = '0; req_age = '0; rob_head = '0;
    endtask

    task automatic set_entry(input int i, input bit mem, input logic [RW-1:0] age);
        req_ready[i] = 1'b1;
        req_mem[i]   = mem;
        req_age[i*RW +: RW] = age;
    endtask

    function automatic logic [NE-1:0] bit_of(input int i);
        logic [NE-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input string name, input logic [2:0] gv,
                            input int i0, input int i1, input int i2,
                            input logic [NE-1:0] clr, input logic busy, input bit chk_gi);
        exp_t x;
        x.name = name; x.gv = gv; x.clr = clr; x.busy = busy; x.chk_gi = chk_gi;
        x.gi = {IW'(i2), IW'(i1), IW'(i0)};
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); clear_inputs();
            if (s < 2) rst = 1'b1;
            push_exp(s < 2 ? "reset" : "idle_after_reset", 3'b000, 0, 0, 0, '0, 1'b0, 1'b1);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (grant_valid !== e.gv) begin n_bad++; $display("FAIL %s grant_valid got %b want %b", e.name, grant_valid, e.gv); end
            n_cmp++; if (grant_idx !== e.gi) begin n_bad++; $display("FAIL %s grant_idx got %h want %h", e.name, grant_idx, e.gi); end
            n_cmp++; if (clear_entry !== e.clr) begin n_bad++; $display("FAIL %s clear_entry got %h want %h", e.name, clear_entry, e.clr); end
            n_cmp++; if (mem_busy !== e.busy) begin n_bad++; $display("FAIL %s mem_busy got %b want %b", e.name, mem_busy, e.busy); end
        end
    endtask

    // rob_head 3: dist 4->4, 9->2, 12->7; same inputs held for two cycles, then idle.
    task automatic test_alu_pair();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk); clear_inputs();
            rob_head = 5'd3;
            if (s < 3) begin set_entry(4, 1'b0, 5'd7); set_entry(9, 1'b0, 5'd5); set_entry(12, 1'b0, 5'd10); end
            case (s)
                0:       push_exp("alu_pair",     3'b011, 9, 4, 0, bit_of(9) | bit_of(4), 1'b0, 1'b1);
                1:       push_exp("alu_masked",   3'b001, 12, 0, 0, bit_of(12), 1'b0, 1'b1);
                2:       push_exp("alu_unmasked", 3'b011, 9, 4, 0, bit_of(9) | bit_of(4), 1'b0, 1'b1);
                default: push_exp("alu_idle",     3'b000, 0, 0, 0, '0, 1'b0, 1'b1);
            endcase
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (grant_valid !== e.gv) begin n_bad++; $display("FAIL %s grant_valid got %b want %b", e.name, grant_valid, e.gv); end
            n_cmp++; if (grant_idx !== e.gi) begin n_bad++; $display("FAIL %s grant_idx got %h want %h", e.name, grant_idx, e.gi); end
            n_cmp++; if (clear_entry !== e.clr) begin n_bad++; $display("FAIL %s clear_entry got %h want %h", e.name, clear_entry, e.clr); end
            n_cmp++; if (mem_busy !== e.busy) begin n_bad++; $display("FAIL %s mem_busy got %b want %b", e.name, mem_busy, e.busy); end
        end
    endtask

    // Wrap-around (head 30: age 31 -> dist 1, age 0 -> dist 2) and equal-age tie.
    task automatic test_age_order();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk); clear_inputs();
            case (s)
                0: begin
                    rob_head = 5'd30; set_entry(1, 1'b0, 5'd31); set_entry(2, 1'b0, 5'd0);
                    push_exp("wrap", 3'b011, 1, 2, 0, bit_of(1) | bit_of(2), 1'b0, 1'b1);
                end
                2: begin
                    rob_head = 5'd0; set_entry(20, 1'b0, 5'd4); set_entry(10, 1'b0, 5'd4);
                    push_exp("tie", 3'b011, 10, 20, 0, bit_of(10) | bit_of(20), 1'b0, 1'b1);
                end
                default: push_exp("age_idle", 3'b000, 0, 0, 0, '0, 1'b0, 1'b1);
            endcase
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (grant_valid !== e.gv) begin n_bad++; $display("FAIL %s grant_valid got %b want %b", e.name, grant_valid, e.gv); end
            n_cmp++; if (grant_idx !== e.gi) begin n_bad++; $display("FAIL %s grant_idx got %h want %h", e.name, grant_idx, e.gi); end
            n_cmp++; if (clear_entry !== e.clr) begin n_bad++; $display("FAIL %s clear_entry got %h want %h", e.name, clear_entry, e.clr); end
            n_cmp++; if (mem_busy !== e.busy) begin n_bad++; $display("FAIL %s mem_busy got %b want %b", e.name, mem_busy, e.busy); end
        end
    endtask

    // MEM occupancy: grant, blocked while busy, done+grant same edge, done clears, stray done ignored.
    task automatic test_mem();
        for (int s = 0; s < 6; s++) begin
            @(negedge clk); clear_inputs();
            case (s)
                0: begin set_entry(5, 1'b1, 5'd2); push_exp("mem_grant", 3'b100, 0, 0, 5, bit_of(5), 1'b1, 1'b1); end
                1: begin set_entry(6, 1'b1, 5'd3); push_exp("mem_blocked", 3'b000, 0, 0, 0, '0, 1'b1, 1'b1); end
                2: begin set_entry(6, 1'b1, 5'd3); mem_done = 1'b1; push_exp("mem_done_grant", 3'b100, 0, 0, 6, bit_of(6), 1'b1, 1'b1); end
                3: push_exp("mem_hold", 3'b000, 0, 0, 0, '0, 1'b1, 1'b1);
                4: begin mem_done = 1'b1; push_exp("mem_release", 3'b000, 0, 0, 0, '0, 1'b0, 1'b1); end
                default: begin mem_done = 1'b1; push_exp("mem_stray_done", 3'b000, 0, 0, 0, '0, 1'b0, 1'b1); end
            endcase
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (grant_valid !== e.gv) begin n_bad++; $display("FAIL %s grant_valid got %b want %b", e.name, grant_valid, e.gv); end
            n_cmp++; if (grant_idx !== e.gi) begin n_bad++; $display("FAIL %s grant_idx got %h want %h", e.name, grant_idx, e.gi); end
            n_cmp++; if (clear_entry !== e.clr) begin n_bad++; $display("FAIL %s clear_entry got %h want %h", e.name, clear_entry, e.clr); end
            n_cmp++; if (mem_busy !== e.busy) begin n_bad++; $display("FAIL %s mem_busy got %b want %b", e.name, mem_busy, e.busy); end
        end
    endtask

    // Flush with MEM busy and ALU work pending, then the same work issues cleanly; ends with a mid-run reset.
    task automatic test_flush_and_reset();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); clear_inputs();
            case (s)
                0: begin set_entry(7, 1'b1, 5'd1); push_exp("pre_flush_mem", 3'b100, 0, 0, 7, bit_of(7), 1'b1, 1'b1); end
                1: begin
                    set_entry(3, 1'b0, 5'd1); set_entry(8, 1'b0, 5'd2); flush = 1'b1;
                    push_exp("flush", 3'b000, 0, 0, 0, '0, 1'b0, 1'b0);
                end
                2: begin
                    set_entry(3, 1'b0, 5'd1); set_entry(8, 1'b0, 5'd2);
                    push_exp("post_flush", 3'b011, 3, 8, 0, bit_of(3) | bit_of(8), 1'b0, 1'b1);
                end
                3: begin
                    set_entry(11, 1'b1, 5'd6); set_entry(14, 1'b0, 5'd9);
                    push_exp("pre_reset", 3'b101, 14, 0, 11, bit_of(11) | bit_of(14), 1'b1, 1'b1);
                end
                default: begin
                    set_entry(15, 1'b0, 5'd0); set_entry(16, 1'b1, 5'd0); rst = 1'b1;
                    push_exp("mid_reset", 3'b000, 0, 0, 0, '0, 1'b0, 1'b1);
                end
            endcase
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (grant_valid !== e.gv) begin n_bad++; $display("FAIL %s grant_valid got %b want %b", e.name, grant_valid, e.gv); end
            if (e.chk_gi) begin
                n_cmp++; if (grant_idx !== e.gi) begin n_bad++; $display("FAIL %s grant_idx got %h want %h", e.name, grant_idx, e.gi); end
            end
            n_cmp++; if (clear_entry !== e.clr) begin n_bad++; $display("FAIL %s clear_entry got %h want %h", e.name, clear_entry, e.clr); end
            n_cmp++; if (mem_busy !== e.busy) begin n_bad++; $display("FAIL %s mem_busy got %b want %b", e.name, mem_busy, e.busy); end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu_pair();
        test_age_order();
        test_mem();
        test_flush_and_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
